game_status_unit: RTL and testbench
===================================

Name: game_status_unit

Overview:
Parametrised successor to the game-over LED controller. It owns the player's lives count instead of only watching it. It runs the game-state FSM (idle, playing, invulnerable after a hit, game over), applies hit and bonus-life events, and drives a blinking game-over LED and a thermometer lives-bar LED array. It sits between the collision/scoring logic and the board LEDs.

Parameters:
LIVES_W, 3, width of the lives count.
START_LIVES, 3, lives loaded on start or restart; must satisfy 1 <= START_LIVES <= MAX_LIVES.
MAX_LIVES, 7, saturation ceiling for bonus lives; must be <= 2**LIVES_W-1.
INVULN_CYCLES, 50, number of cycles spent in INVULN after a non-fatal hit; must be >= 1.
BLINK_DIV, 25000000, cycles per half-period of the game-over LED blink; must be >= 1.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset; named as in the codebase, low = in reset
start  input  1  single-cycle pulse: begin a game (IDLE) or restart (OVER)
hit  input  1  single-cycle pulse: player was hit
bonus  input  1  single-cycle pulse: award one extra life
lives  output  LIVES_W  current lives count
game_over  output  1  high while in OVER
led_over  output  1  game-over LED, blinks in OVER
led_lives  output  MAX_LIVES  thermometer bar; bit i = 1 iff lives > i
hit_flash  output  1  high while in INVULN

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, lives=0, game_over=0, led_over=0, led_lives=0, hit_flash=0.
  - Invulnerability counter=0, blink counter=0.
  - Release is synchronous to clk.
- All outputs are registered. An event on an input edge is visible on the outputs after that edge, i.e. 1-cycle latency.
- IDLE:
  - start -> PLAYING, lives=START_LIVES.
  - hit and bonus are ignored.
- PLAYING, with hit=1:
  - If lives==1: lives=0 -> OVER.
  - Otherwise: lives-1 -> INVULN, inv_cnt=INVULN_CYCLES-1.
- PLAYING, with bonus=1 and hit=0: lives = min(lives+1, MAX_LIVES). State stays PLAYING.
- hit and bonus in the same cycle: hit is processed, bonus is dropped. This rule applies in every state that accepts hit.
- INVULN:
  - hit is ignored.
  - bonus is accepted with the same saturation rule.
  - inv_cnt decrements each cycle. On the cycle inv_cnt==0, return to PLAYING.
  - hit_flash=1 for exactly INVULN_CYCLES cycles.
  - A hit on the first PLAYING cycle after INVULN is accepted.
- OVER:
  - game_over=1, lives=0.
  - hit and bonus are ignored.
  - led_over=1 on entry, then toggles every BLINK_DIV cycles. The blink counter is cleared on entry.
  - start -> PLAYING, lives=START_LIVES, game_over=0, led_over=0, blink counter cleared.
- start while in PLAYING or INVULN is ignored.
- Outside OVER: led_over=0 and the blink counter is held at 0.
- Arithmetic:
  - lives never underflows below 0 and never exceeds MAX_LIVES.
  - Counters are sized with $clog2 of their terminal value, minimum 1 bit.
- Reset asserted mid-game, mid-INVULN or mid-blink: immediate return to the reset values, with no partial state retained.
- Undefined state encodings recover to IDLE.

Test Plan:
1. Reset, start pulse -> lives=3, led_lives=0000111, game_over=0. Then 3 hits, each spaced more than INVULN_CYCLES apart -> lives 2,1,0; after the third hit game_over=1 and led_over=1.
2. Hit at lives=3 with INVULN_CYCLES=4 -> hit_flash high for exactly 4 cycles. A second hit inside that window is ignored (lives stays 2). A hit on the first cycle after the window -> lives=1.
3. Bonus pulses from lives=6 -> 7, then further bonus pulses hold at 7 with led_lives=1111111. Simultaneous hit+bonus at lives=5 -> lives=4 and INVULN entered.
4. In OVER with BLINK_DIV=3 -> led_over pattern 1,1,1,0,0,0,1… Start pulse -> lives=3, led_over=0, game_over=0 on the next cycle.
5. Drive reset low asynchronously mid-INVULN and mid-blink -> outputs go to 0 without waiting for a clk edge. After release, hit/bonus are ignored until start.
6. Start pulse while PLAYING with lives=2 -> lives stays 2; no restart.

Source files
------------

// File: rtl/game_status_unit_if.sv
// game_status_unit_if: event pulses into, and status/LED outputs out of, the game status unit.
// Rev 1.0
`default_nettype none

interface game_status_unit_if #(
  parameter int LIVES_W   = 3,
  parameter int MAX_LIVES = 7
);
  logic                 start;
  logic                 hit;
  logic                 bonus;
  logic [LIVES_W-1:0]   lives;
  logic                 game_over;
  logic                 led_over;
  logic [MAX_LIVES-1:0] led_lives;
  logic                 hit_flash;

  modport master (
    output start, hit, bonus,
    input  lives, game_over, led_over, led_lives, hit_flash
  );

  modport slave (
    input  start, hit, bonus,
    output lives, game_over, led_over, led_lives, hit_flash
  );
endinterface

`default_nettype wire

// File: rtl/game_status_unit.sv
// game_status_unit: owns the lives count, runs the game-state FSM and drives the status LEDs.
// Rev 1.0
`default_nettype none

module game_status_unit #(
  parameter int LIVES_W       = 3,
  parameter int START_LIVES   = 3,
  parameter int MAX_LIVES     = 7,
  parameter int INVULN_CYCLES = 50,
  parameter int BLINK_DIV     = 25000000
) (
  input  wire                     clk,
  input  wire                     reset,
  game_status_unit_if.slave       bus
);

  localparam int INV_W   = (INVULN_CYCLES > 1) ? $clog2(INVULN_CYCLES) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [LIVES_W-1:0] C_START_LIVES = LIVES_W'(START_LIVES);
  localparam logic [LIVES_W-1:0] C_MAX_LIVES   = LIVES_W'(MAX_LIVES);
  localparam logic [INV_W-1:0]   C_INV_LOAD    = INV_W'(INVULN_CYCLES - 1);
  localparam logic [BLINK_W-1:0] C_BLINK_LAST  = BLINK_W'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAYING = 2'd1,
    INVULN  = 2'd2,
    OVER    = 2'd3
  } state_t;

  state_t               state;
  logic [LIVES_W-1:0]   lives;
  logic [LIVES_W-1:0]   lives_nxt;
  logic [INV_W-1:0]     inv_cnt;
  logic [BLINK_W-1:0]   blink_cnt;
  logic                 game_over;
  logic                 led_over;
  logic [MAX_LIVES-1:0] led_lives;
  logic                 hit_flash;

  function automatic logic [MAX_LIVES-1:0] therm(input logic [LIVES_W-1:0] n);
    logic [MAX_LIVES-1:0] t;
    t = '0;
    for (int i = 0; i < MAX_LIVES; i++) begin
      t[i] = (int'(n) > i);
    end
    return t;
  endfunction

  function automatic logic [LIVES_W-1:0] add_life(input logic [LIVES_W-1:0] n);
    return (n >= C_MAX_LIVES) ? C_MAX_LIVES : n + LIVES_W'(1);
  endfunction

  // Next lives value is shared by the lives register and the thermometer bar
  always_comb begin
    lives_nxt = lives;
    case (state)
      IDLE: begin
        if (bus.start) lives_nxt = C_START_LIVES;
      end
      PLAYING: begin
        if (bus.hit) begin
          lives_nxt = (lives != '0) ? lives - LIVES_W'(1) : '0;
        end else if (bus.bonus) begin
          lives_nxt = add_life(lives);
        end
      end
      INVULN: begin
        if (bus.bonus) lives_nxt = add_life(lives);
      end
      OVER: begin
        lives_nxt = bus.start ? C_START_LIVES : '0;
      end
      default: lives_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      lives     <= '0;
      inv_cnt   <= '0;
      blink_cnt <= '0;
      game_over <= 1'b0;
      led_over  <= 1'b0;
      led_lives <= '0;
      hit_flash <= 1'b0;
    end else begin
      lives     <= lives_nxt;
      led_lives <= therm(lives_nxt);
      case (state)
        IDLE: begin
          if (bus.start) state <= PLAYING;
        end
        PLAYING: begin
          if (bus.hit) begin
            if (lives <= LIVES_W'(1)) begin
              state     <= OVER;
              game_over <= 1'b1;
              led_over  <= 1'b1;
              blink_cnt <= '0;
            end else begin
              state     <= INVULN;
              inv_cnt   <= C_INV_LOAD;
              hit_flash <= 1'b1;
            end
          end
        end
        INVULN: begin
          if (inv_cnt == '0) begin
            state     <= PLAYING;
            hit_flash <= 1'b0;
          end else begin
            inv_cnt <= inv_cnt - INV_W'(1);
          end
        end
        OVER: begin
          if (bus.start) begin
            state     <= PLAYING;
            game_over <= 1'b0;
            led_over  <= 1'b0;
            blink_cnt <= '0;
          end else if (blink_cnt == C_BLINK_LAST) begin
            blink_cnt <= '0;
            led_over  <= ~led_over;
          end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          inv_cnt   <= '0;
          blink_cnt <= '0;
          game_over <= 1'b0;
          led_over  <= 1'b0;
          hit_flash <= 1'b0;
        end
      endcase
    end
  end

  assign bus.lives     = lives;
  assign bus.game_over = game_over;
  assign bus.led_over  = led_over;
  assign bus.led_lives = led_lives;
  assign bus.hit_flash = hit_flash;

endmodule

`default_nettype wire

// File: tb/tb_game_status_unit.sv
// tb_game_status_unit: directed and random checks of game_status_unit against a behavioural model.
// Rev 1.0
`default_nettype none

module tb_game_status_unit;

  localparam int LW = 3;
  localparam int SL = 3;
  localparam int ML = 7;
  localparam int IC = 4;
  localparam int BD = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: lives as an integer, a "cycles of flash left" count,
  // and the number of cycles elapsed since the game ended.
  int m_lives   = 0;
  bit m_started = 0;
  bit m_over    = 0;
  int m_inv     = 0;
  int m_blink   = 0;

  game_status_unit_if #(.LIVES_W(LW), .MAX_LIVES(ML)) bus ();

  game_status_unit #(
    .LIVES_W      (LW),
    .START_LIVES  (SL),
    .MAX_LIVES    (ML),
    .INVULN_CYCLES(IC),
    .BLINK_DIV    (BD)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic int plus_one(input int n);
    return (n + 1 > ML) ? ML : n + 1;
  endfunction

  task automatic model_reset();
    m_lives = 0; m_started = 0; m_over = 0; m_inv = 0; m_blink = 0;
  endtask

  task automatic model_step(input bit s, input bit h, input bit b);
    if (m_over) begin
      if (s) begin m_over = 0; m_lives = SL; end
      else m_blink++;
    end else if (!m_started) begin
      if (s) begin m_started = 1; m_lives = SL; end
    end else if (m_inv > 0) begin
      m_inv--;
      if (b) m_lives = plus_one(m_lives);
    end else if (h) begin
      m_lives--;
      if (m_lives == 0) begin m_over = 1; m_blink = 0; end
      else m_inv = IC;
    end else if (b) begin
      m_lives = plus_one(m_lives);
    end
  endtask

  task automatic check_all(input string tag);
    logic [LW-1:0] e_lives;
    logic [ML-1:0] e_bar;
    logic          e_over, e_led, e_flash;
    e_lives = LW'(m_lives);
    e_bar   = ML'((1 << m_lives) - 1);
    e_over  = m_over;
    e_led   = m_over && (((m_blink / BD) % 2) == 0);
    e_flash = (m_inv > 0);
    checks++;
    assert (bus.lives === e_lives) else begin
      failures++; $error("FAIL %s lives obs=%0d exp=%0d", tag, bus.lives, e_lives);
    end
    checks++;
    assert (bus.led_lives === e_bar) else begin
      failures++; $error("FAIL %s led_lives obs=%b exp=%b", tag, bus.led_lives, e_bar);
    end
    checks++;
    assert (bus.game_over === e_over) else begin
      failures++; $error("FAIL %s game_over obs=%b exp=%b", tag, bus.game_over, e_over);
    end
    checks++;
    assert (bus.led_over === e_led) else begin
      failures++; $error("FAIL %s led_over obs=%b exp=%b", tag, bus.led_over, e_led);
    end
    checks++;
    assert (bus.hit_flash === e_flash) else begin
      failures++; $error("FAIL %s hit_flash obs=%b exp=%b", tag, bus.hit_flash, e_flash);
    end
  endtask

  // One clock: inputs applied now, model advanced at the edge, outputs checked 1 time unit later
  task automatic cycle(input bit s, input bit h, input bit b, input string tag);
    bus.start = s; bus.hit = h; bus.bonus = b;
    @(posedge clk);
    model_step(s, h, b);
    #1;
    bus.start = 0; bus.hit = 0; bus.bonus = 0;
    check_all(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, tag);
  endtask

  // Asynchronous reset between clock edges, checked before any further edge
  task automatic async_reset(input string tag);
    #3;
    reset = 0;
    model_reset();
    #1;
    check_all(tag);
    @(posedge clk);
    #1;
    check_all(tag);
    #2;
    reset = 1;
  endtask

  initial begin
    bus.start = 0; bus.hit = 0; bus.bonus = 0;
    #2;
    check_all("reset_state");
    #10;
    reset = 1;

    // Start and lose all three lives, hits spaced beyond the flash window
    cycle(1, 0, 0, "t1_start");
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1, 0, "t1_hit");
      idle(IC + 2, "t1_wait");
    end

    // Blink pattern in OVER, then restart
    idle(7, "t4_blink");
    cycle(1, 0, 0, "t4_restart");

    // Flash window: hit inside ignored, hit on the first cycle after accepted
    cycle(0, 1, 0, "t2_hit");
    cycle(0, 0, 0, "t2_win");
    cycle(0, 1, 0, "t2_hit_in_win");
    idle(2, "t2_win");
    cycle(0, 1, 0, "t2_hit_after");
    idle(IC + 1, "t2_wait");

    // Bonus saturation from 1 up to the ceiling and beyond
    for (int k = 0; k < 8; k++) cycle(0, 0, 1, "t3_bonus");
    cycle(0, 1, 0, "t3_hit");
    idle(IC + 1, "t3_wait");
    cycle(0, 1, 0, "t3_hit");
    idle(IC + 1, "t3_wait");
    cycle(0, 1, 1, "t3_hit_bonus");
    cycle(1, 0, 0, "t6_start_invuln");
    idle(IC + 1, "t3_wait");

    // Start while playing is ignored
    cycle(0, 1, 0, "t6_hit");
    idle(IC + 1, "t6_wait");
    cycle(0, 1, 0, "t6_hit");
    idle(IC + 1, "t6_wait");
    cycle(1, 0, 0, "t6_start_playing");
    idle(2, "t6_hold");

    // Random event stream
    for (int k = 0; k < 600; k++) begin
      cycle($urandom_range(0, 99) < 5, $urandom_range(0, 99) < 12,
            $urandom_range(0, 99) < 12, "rand");
    end

    // Async reset mid-INVULN, then events before start are ignored
    async_reset("t5_reset_a");
    cycle(1, 0, 0, "t5_start");
    cycle(0, 1, 0, "t5_hit");
    cycle(0, 0, 0, "t5_invuln");
    async_reset("t5_reset_invuln");
    cycle(0, 1, 0, "t5_idle_hit");
    cycle(0, 0, 1, "t5_idle_bonus");
    idle(2, "t5_idle");

    // Async reset mid-blink
    cycle(1, 0, 0, "t5_start2");
    for (int k = 0; k < SL; k++) begin
      cycle(0, 1, 0, "t5_hit2");
      idle(IC + 1, "t5_wait2");
    end
    async_reset("t5_reset_blink");
    cycle(0, 1, 1, "t5_after");
    cycle(1, 0, 0, "t5_start3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
